// File: rtl/square_freq_meter_pkg.sv
// Shared types and constants for the square-wave frequency meter.
package square_freq_meter_pkg;

    localparam int unsigned SYS_CLK_FREQ  = 48_000_000;
    localparam int unsigned F_MIN         = 20;
    localparam int unsigned METER_HYST    = 256;
    localparam int unsigned METER_MAX_CTR = SYS_CLK_FREQ / F_MIN;

    localparam int unsigned SYNTH_SIG_W = 16;
    localparam int unsigned REG_DATA_W  = 16;

    typedef logic signed [SYNTH_SIG_W-1:0] synth_sig;
    typedef logic [REG_DATA_W-1:0]         reg_data_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } meter_state_t;

endpackage

// File: rtl/square_polarity_det.sv
// Registers the waveform, tracks its polarity with hysteresis and emits a
// one-cycle pulse whenever the polarity flips.
module square_polarity_det
    import square_freq_meter_pkg::*;
#(
    parameter int unsigned HYST = METER_HYST
) (
    input  logic     clk_in,
    input  logic     reset,
    input  synth_sig sig_in,
    output logic     edge_pulse
);

    localparam synth_sig HYST_HI = synth_sig'(HYST);
    localparam synth_sig HYST_LO = -HYST_HI;

    synth_sig sig_q;
    logic     pol_q;
    logic     pol_c;

    // Inside the dead band the previous polarity is kept.
    always_comb begin
        pol_c = pol_q;
        if (sig_q > HYST_HI) begin
            pol_c = 1'b1;
        end else if (sig_q < HYST_LO) begin
            pol_c = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sig_q      <= '0;
            pol_q      <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sig_q      <= sig_in;
            pol_q      <= pol_c;
            edge_pulse <= (pol_c != pol_q);
        end
    end

endmodule

// File: rtl/square_freq_meter.sv
// Measures the averaged half-period of a synth-domain square wave and reports
// it as half-period minus one clock, matching the generator's freq_in units.
module square_freq_meter
    import square_freq_meter_pkg::*;
#(
    parameter int unsigned CLK_FREQ = SYS_CLK_FREQ,
    parameter int unsigned HYST     = METER_HYST,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic      clk_in,
    input  logic      reset,
    input  logic      enable,
    input  synth_sig  sig_in,
    output reg_data_t freq_out,
    output logic      freq_valid,
    output logic      meas_strobe,
    output logic      timeout
);

    localparam int unsigned MAX_CTR = CLK_FREQ / F_MIN;
    localparam int unsigned CW      = $clog2(MAX_CTR) + 1;
    localparam int unsigned AW      = CW + AVG_LOG2;
    localparam int unsigned NW      = AVG_LOG2 + 1;
    localparam int unsigned RW      = $bits(reg_data_t);
    localparam int unsigned WW      = (AW > RW) ? AW : RW;

    localparam logic [CW-1:0] MAX_CTR_C = CW'(MAX_CTR);
    localparam logic [NW-1:0] N_AVG     = NW'(1 << AVG_LOG2);
    localparam logic [WW-1:0] REG_MAX_W = WW'({RW{1'b1}});

    meter_state_t  state;
    logic [CW-1:0] hp_ctr;
    logic [AW-1:0] acc;
    logic [NW-1:0] n_cnt;
    logic          edge_pulse;

    logic [AW-1:0] acc_sum_c;
    logic [NW-1:0] n_next_c;
    logic [WW-1:0] avg_wide_c;
    reg_data_t     avg_sat_c;

    square_polarity_det #(
        .HYST(HYST)
    ) u_pol (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_in    (sig_in),
        .edge_pulse(edge_pulse)
    );

    // Running sum including the sample closing at this edge, and its clamped average.
    assign acc_sum_c  = acc + AW'(hp_ctr - CW'(1));
    assign n_next_c   = n_cnt + NW'(1);
    assign avg_wide_c = WW'(acc_sum_c >> AVG_LOG2);
    assign avg_sat_c  = (avg_wide_c > REG_MAX_W) ? {RW{1'b1}} : RW'(avg_wide_c);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hp_ctr      <= '0;
            acc         <= '0;
            n_cnt       <= '0;
            freq_out    <= '0;
            freq_valid  <= 1'b0;
            meas_strobe <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_strobe <= 1'b0;
            if (!enable) begin
                // Leaving enable drops any partial accumulation; timeout stays sticky.
                state      <= IDLE;
                hp_ctr     <= '0;
                acc        <= '0;
                n_cnt      <= '0;
                freq_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        freq_valid <= 1'b0;
                        state      <= ARM;
                    end
                    ARM: begin
                        if (edge_pulse) begin
                            state  <= MEASURE;
                            hp_ctr <= CW'(1);
                            acc    <= '0;
                            n_cnt  <= '0;
                        end else if (hp_ctr == MAX_CTR_C) begin
                            timeout    <= 1'b1;
                            freq_valid <= 1'b0;
                            hp_ctr     <= CW'(1);
                        end else begin
                            hp_ctr <= hp_ctr + CW'(1);
                        end
                    end
                    MEASURE: begin
                        // An edge arriving on the MAX_CTR count still counts as a sample.
                        if (edge_pulse) begin
                            hp_ctr <= CW'(1);
                            if (n_next_c == N_AVG) begin
                                freq_out    <= avg_sat_c;
                                meas_strobe <= 1'b1;
                                freq_valid  <= 1'b1;
                                timeout     <= 1'b0;
                                acc         <= '0;
                                n_cnt       <= '0;
                            end else begin
                                acc   <= acc_sum_c;
                                n_cnt <= n_next_c;
                            end
                        end else if (hp_ctr == MAX_CTR_C) begin
                            timeout    <= 1'b1;
                            freq_valid <= 1'b0;
                            state      <= ARM;
                            hp_ctr     <= CW'(1);
                        end else begin
                            hp_ctr <= hp_ctr + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_square_freq_meter.sv
// Self-checking bench for square_freq_meter: table vectors, randomized
// half-period streams against a toggle-time model, and hand-written corner cases.
module tb_square_freq_meter;
    import square_freq_meter_pkg::*;

    localparam int unsigned CLK_FREQ = 40_000;
    localparam int unsigned MAX_CTR  = CLK_FREQ / F_MIN;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int          NAVG     = 1 << AVG_LOG2;

    logic      clk_in = 1'b0;
    logic      reset;
    logic      enable;
    synth_sig  sig_in;
    reg_data_t freq_out;
    logic      freq_valid;
    logic      meas_strobe;
    logic      timeout;

    square_freq_meter #(
        .CLK_FREQ(CLK_FREQ),
        .HYST    (METER_HYST),
        .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .sig_in     (sig_in),
        .freq_out   (freq_out),
        .freq_valid (freq_valid),
        .meas_strobe(meas_strobe),
        .timeout    (timeout)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int hp_a;
        int hp_b;
        int exp_freq;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   lvl      = 0;
    int   amp      = 1000;
    int   last_exp = 0;
    int   tq[$];
    int   s_cyc[$];
    int   s_val[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        if (meas_strobe) begin
            s_cyc.push_back(cyc);
            s_val.push_back(int'(freq_out));
        end
    endtask

    task automatic ticks(input int k);
        repeat (k) tick();
    endtask

    // Toggle the square wave and hold the new level for p clocks.
    task automatic half(input int p);
        lvl    = 1 - lvl;
        sig_in = synth_sig'((lvl != 0) ? amp : -amp);
        tq.push_back(cyc);
        ticks(p);
    endtask

    task automatic clear_log();
        tq.delete();
        s_cyc.delete();
        s_val.delete();
    endtask

    task automatic rearm();
        enable = 1'b0;
        ticks(2);
        clear_log();
        enable = 1'b1;
        ticks(2);
    endtask

    // First logged toggle arms; each later gap g gives sample g-1; every NAVG samples
    // the floor average appears 3 clocks after the toggle that completes the set.
    task automatic model_check(input string tag);
        int exp_cyc[$];
        int exp_val[$];
        int sum;
        int cnt;
        sum = 0;
        cnt = 0;
        for (int i = 1; i < tq.size(); i++) begin
            sum += tq[i] - tq[i-1] - 1;
            cnt++;
            if (cnt == NAVG) begin
                exp_cyc.push_back(tq[i] + 3);
                exp_val.push_back((sum / NAVG > 65535) ? 65535 : sum / NAVG);
                sum = 0;
                cnt = 0;
            end
        end
        check({tag, "_count"}, s_val.size(), exp_val.size());
        for (int i = 0; i < exp_val.size() && i < s_val.size(); i++) begin
            check({tag, "_val"}, s_val[i], exp_val[i]);
            check({tag, "_cyc"}, s_cyc[i], exp_cyc[i]);
        end
        if (exp_val.size() > 0) last_exp = exp_val[exp_val.size()-1];
    endtask

    initial begin
        int e;
        int hl;
        int noise;

        vecs[0] = '{100, 100, 99};
        vecs[1] = '{10, 12, 10};
        vecs[2] = '{50, 50, 49};
        vecs[3] = '{7, 9, 7};
        vecs[4] = '{3, 4, 2};
        vecs[5] = '{20, 25, 21};
        vecs[6] = '{2000, 2000, 1999};

        reset  = 1'b1;
        enable = 1'b0;
        sig_in = synth_sig'(-amp);
        ticks(3);
        check("rst_freq_out", int'(freq_out), 0);
        check("rst_valid", int'(freq_valid), 0);
        check("rst_strobe", int'(meas_strobe), 0);
        check("rst_timeout", int'(timeout), 0);
        reset = 1'b0;
        ticks(2);
        check("idle_valid", int'(freq_valid), 0);

        // Alternating half-periods a,b,a,b after one arming toggle.
        for (int v = 0; v < 7; v++) begin
            rearm();
            half(vecs[v].hp_a);
            half(vecs[v].hp_b);
            half(vecs[v].hp_a);
            half(vecs[v].hp_b);
            half(vecs[v].hp_a);
            check("tbl_strobes", s_val.size(), 1);
            check("tbl_freq", int'(freq_out), vecs[v].exp_freq);
            check("tbl_valid", int'(freq_valid), 1);
            check("tbl_timeout", int'(timeout), 0);
            if (s_cyc.size() > 0) check("tbl_latency", s_cyc[0] - tq[4], 3);
        end

        // Loopback-like continuous stream with freq_in = 99.
        rearm();
        for (int i = 0; i < 13; i++) half(100);
        model_check("loop");
        if (s_cyc.size() >= 3) begin
            check("loop_period1", s_cyc[1] - s_cyc[0], 400);
            check("loop_period2", s_cyc[2] - s_cyc[1], 400);
        end

        // Random half-periods and amplitudes.
        for (int r = 0; r < 8; r++) begin
            rearm();
            amp = int'($urandom_range(30000, 300));
            for (int i = 0; i < 9; i++) half(int'($urandom_range(60, 3)));
            model_check("rand");
            check("rand_valid", int'(freq_valid), 1);
        end

        // Square wave confined to the dead band: no edges, so a timeout follows.
        enable = 1'b0;
        ticks(2);
        clear_log();
        enable = 1'b1;
        e = cyc;
        hl = 0;
        for (int k = 0; k < int'(MAX_CTR) + 4; k++) begin
            if (k % 37 == 0) hl = 1 - hl;
            noise  = int'($urandom_range(112, 0)) - 56;
            sig_in = synth_sig'(((hl != 0) ? 200 : -200) + noise);
            tick();
            if (cyc == e + int'(MAX_CTR) - 2) check("hyst_no_timeout_yet", int'(timeout), 0);
        end
        check("hyst_timeout", int'(timeout), 1);
        check("hyst_valid", int'(freq_valid), 0);
        check("hyst_strobes", s_val.size(), 0);
        check("hyst_freq_held", int'(freq_out), last_exp);

        // Timeout recovery: 100-clock halves, stuck high, then 50-clock halves.
        amp = 1000;
        sig_in = synth_sig'((lvl != 0) ? amp : -amp);
        rearm();
        for (int i = 0; i < 5; i++) half(100);
        check("rec_first", int'(freq_out), 99);
        if (lvl == 0) begin
            lvl = 1;
            tq.push_back(cyc);
        end
        sig_in = synth_sig'(32767);
        ticks(int'(MAX_CTR) + 20);
        check("rec_timeout", int'(timeout), 1);
        check("rec_valid_low", int'(freq_valid), 0);
        check("rec_state_arm", int'(dut.state), int'(ARM));
        check("rec_freq_held", int'(freq_out), 99);
        clear_log();
        for (int i = 0; i < 5; i++) half(50);
        check("rec_strobes", s_val.size(), 1);
        check("rec_freq", int'(freq_out), 49);
        check("rec_timeout_clr", int'(timeout), 0);
        check("rec_valid", int'(freq_valid), 1);

        // One-cycle enable drop with two samples accumulated.
        half(30);
        half(30);
        check("drop_valid_before", int'(freq_valid), 1);
        enable = 1'b0;
        tick();
        check("drop_valid_after", int'(freq_valid), 0);
        check("drop_state_idle", int'(dut.state), int'(IDLE));
        enable = 1'b1;
        clear_log();
        for (int i = 0; i < 5; i++) half(80);
        model_check("drop");
        check("drop_freq", int'(freq_out), 79);
        check("drop_valid", int'(freq_valid), 1);

        // Asynchronous reset in the middle of MEASURE.
        half(25);
        half(25);
        #2;
        reset  = 1'b1;
        lvl    = 0;
        sig_in = synth_sig'(-amp);
        #1;
        check("arst_freq_out", int'(freq_out), 0);
        check("arst_valid", int'(freq_valid), 0);
        check("arst_strobe", int'(meas_strobe), 0);
        check("arst_timeout", int'(timeout), 0);
        ticks(2);
        reset = 1'b0;
        clear_log();
        ticks(3);
        for (int i = 0; i < 5; i++) half(25);
        model_check("arst");
        check("arst_freq", int'(freq_out), 24);
        check("arst_valid_after", int'(freq_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
